// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM-subset core: sequences the shared datapath,
// keeps the NZCV flags and gates every write enable on the evaluated condition.
module multicycle_controller #(
    parameter int PC_IDX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } stateT;

    localparam logic [3:0] pcIdx = 4'(PC_IDX);

    stateT state;
    logic  condexQ;
    logic  condEx;
    logic  irWrite, nextPc, regW, memW, branch, aluOp;
    logic  noWrite;
    logic  flagN, flagZ, flagC, flagV;

    assign {flagN, flagZ, flagC, flagV} = Flags;

    // State, latched condition result and the flag register share one sequential block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH;
            Flags   <= 4'b0000;
            condexQ <= 1'b0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (Op)
                        2'b00:   state <= Funct[5] ? EXECI : EXECR;
                        2'b01:   state <= MEMADR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXECR,
                EXECI:  state <= ALUWB;
                default: state <= FETCH;
            endcase

            if (state == DECODE)
                condexQ <= condEx;

            // Logical ops (AND/ORR) have no meaningful carry/overflow, so C and V are kept.
            if ((state == EXECR || state == EXECI) && Funct[0] && condexQ) begin
                Flags[3:2] <= ALUFlags[3:2];
                if (!ALUControl[1])
                    Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        irWrite   = 1'b0;
        nextPc    = 1'b0;
        regW      = 1'b0;
        memW      = 1'b0;
        branch    = 1'b0;
        aluOp     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state)
            FETCH: begin
                irWrite   = 1'b1;
                nextPc    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                memW   = 1'b1;
            end
            EXECR:  aluOp = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                aluOp   = 1'b1;
            end
            ALUWB:  regW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        if (aluOp) begin
            case (Funct[4:1])
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                4'b1010: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
        end
    end

    // CMP suppresses the write-back for the whole instruction, not just the execute cycle.
    assign noWrite = (Op == 2'b00) && (Funct[4:1] == 4'b1010);

    always_comb begin
        condEx = 1'b0;
        case (Cond)
            4'b0000: condEx = flagZ;
            4'b0001: condEx = ~flagZ;
            4'b0010: condEx = flagC;
            4'b0011: condEx = ~flagC;
            4'b0100: condEx = flagN;
            4'b0101: condEx = ~flagN;
            4'b0110: condEx = flagV;
            4'b0111: condEx = ~flagV;
            4'b1000: condEx = flagC & ~flagZ;
            4'b1001: condEx = ~flagC | flagZ;
            4'b1010: condEx = (flagN == flagV);
            4'b1011: condEx = (flagN != flagV);
            4'b1100: condEx = ~flagZ & (flagN == flagV);
            4'b1101: condEx = flagZ | (flagN != flagV);
            4'b1110: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end

    // Enables are also gated by rst so an abandoned instruction cannot write anything.
    assign IRWrite  = rst & irWrite;
    assign RegWrite = rst & regW & condexQ & ~noWrite;
    assign MemWrite = rst & memW & condexQ;
    assign PCWrite  = rst & (nextPc | (condexQ & (branch | (regW & (Rd == pcIdx) & ~noWrite))));

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign State  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0] ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0] Flags, State;

    int total = 0;
    int bad   = 0;

    logic [3:0] obsState [0:7];
    logic       obsPcw [0:7], obsIrw [0:7], obsMw [0:7], obsRw [0:7], obsAdr [0:7];
    logic [1:0] obsRes [0:7], obsAluc [0:7];
    logic [3:0] aluIn [0:7];

    multicycle_controller #(.PC_IDX(15)) dut (
        .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .RegSrc(RegSrc), .Flags(Flags), .State(State)
    );

    always #5 clk = ~clk;

    // Holds one instruction on the inputs for n cycles, recording outputs mid-cycle.
    task automatic runInstr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r, input int n, input logic [3:0] af,
                            input bit randAf);
        Cond = c; Op = o; Funct = f; Rd = r;
        for (int k = 0; k < n; k++) begin
            ALUFlags = randAf ? 4'($urandom) : af;
            aluIn[k] = ALUFlags;
            #1;
            obsState[k] = State;  obsPcw[k] = PCWrite; obsIrw[k] = IRWrite;
            obsMw[k]    = MemWrite; obsRw[k] = RegWrite; obsAdr[k] = AdrSrc;
            obsRes[k]   = ResultSrc; obsAluc[k] = ALUControl;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic bit condPass(input logic [3:0] c, input logic [3:0] fl);
        bit n, z, cy, v;
        {n, z, cy, v} = fl;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int instrLen(input logic [1:0] o, input logic [5:0] f);
        case (o)
            2'b00:   return 4;
            2'b01:   return f[0] ? 5 : 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [3:0] phaseState(input logic [1:0] o, input logic [5:0] f, input int k);
        if (k == 0) return 4'd0;
        if (k == 1) return 4'd1;
        case (o)
            2'b01:   return (k == 2) ? 4'd2 : (f[0] ? ((k == 3) ? 4'd3 : 4'd4) : 4'd5);
            2'b00:   return (k == 2) ? (f[5] ? 4'd7 : 4'd6) : 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [1:0] aluModel(input logic [3:0] cmd);
        case (cmd)
            4'd2, 4'd10: return 2'b01;
            4'd0:        return 2'b10;
            4'd12:       return 2'b11;
            default:     return 2'b00;
        endcase
    endfunction

    task automatic test_reset();
        #1;
        total++; if (State !== 4'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", State); end
        total++; if (Flags !== 4'd0) begin bad++; $display("[TB] FAIL reset_flags: got %b want 0000", Flags); end
        total++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_enables: got %b want 0000", {PCWrite, IRWrite, MemWrite, RegWrite});
        end
        total++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b11010) begin
            bad++; $display("[TB] FAIL reset_fetch_sel: got %b want 11010", {ALUSrcA, ALUSrcB, ResultSrc});
        end
        @(negedge clk);
        rst = 1'b1;
        runInstr(4'hE, 2'b11, 6'd0, 4'd0, 2, 4'd0, 1'b0);
        total++; if ({obsIrw[0], obsPcw[0]} !== 2'b11) begin
            bad++; $display("[TB] FAIL first_fetch: got %b want 11", {obsIrw[0], obsPcw[0]});
        end
        total++; if (obsState[1] !== 4'd1) begin bad++; $display("[TB] FAIL first_decode: got %0d want 1", obsState[1]); end
    endtask

    task automatic test_load();
        logic [3:0] seq [0:4] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        runInstr(4'hE, 2'b01, 6'b011001, 4'd3, 5, 4'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            total++; if (obsState[k] !== seq[k]) begin bad++; $display("[TB] FAIL load_state[%0d]: got %0d want %0d", k, obsState[k], seq[k]); end
            total++; if (obsRw[k] !== (k == 4)) begin bad++; $display("[TB] FAIL load_regwrite[%0d]: got %b want %b", k, obsRw[k], k == 4); end
        end
        total++; if (obsAdr[3] !== 1'b1) begin bad++; $display("[TB] FAIL load_adrsrc: got %b want 1", obsAdr[3]); end
        total++; if (obsRes[4] !== 2'b01) begin bad++; $display("[TB] FAIL load_resultsrc: got %b want 01", obsRes[4]); end
        #1;
        total++; if (State !== 4'd0) begin bad++; $display("[TB] FAIL load_return: got %0d want 0", State); end
    endtask

    task automatic test_store_cond();
        logic [3:0] seq [0:3] = '{4'd0, 4'd1, 4'd2, 4'd5};
        runInstr(4'h0, 2'b01, 6'b011000, 4'd2, 4, 4'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++; if (obsState[k] !== seq[k]) begin bad++; $display("[TB] FAIL store_state[%0d]: got %0d want %0d", k, obsState[k], seq[k]); end
            total++; if (obsMw[k] !== 1'b0) begin bad++; $display("[TB] FAIL store_eq_fail_mw[%0d]: got %b want 0", k, obsMw[k]); end
        end
        runInstr(4'hE, 2'b00, 6'b001001, 4'd1, 4, 4'b0100, 1'b0);
        #1;
        total++; if (Flags !== 4'b0100) begin bad++; $display("[TB] FAIL adds_set_z: got %b want 0100", Flags); end
        runInstr(4'h0, 2'b01, 6'b011000, 4'd2, 4, 4'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++; if (obsMw[k] !== (k == 3)) begin bad++; $display("[TB] FAIL store_eq_pass_mw[%0d]: got %b want %b", k, obsMw[k], k == 3); end
        end
    endtask

    task automatic test_cmp_branch();
        runInstr(4'hE, 2'b00, 6'b010101, 4'd0, 4, 4'b0100, 1'b0);
        #1;
        total++; if (Flags !== 4'b0100) begin bad++; $display("[TB] FAIL cmp_flags: got %b want 0100", Flags); end
        total++; if (obsState[2] !== 4'd6) begin bad++; $display("[TB] FAIL cmp_execr: got %0d want 6", obsState[2]); end
        total++; if (obsRw[3] !== 1'b0) begin bad++; $display("[TB] FAIL cmp_nowrite: got %b want 0", obsRw[3]); end
        runInstr(4'h0, 2'b10, 6'b100000, 4'd0, 3, 4'd0, 1'b0);
        total++; if (obsState[2] !== 4'd9) begin bad++; $display("[TB] FAIL beq_state: got %0d want 9", obsState[2]); end
        total++; if (obsPcw[2] !== 1'b1) begin bad++; $display("[TB] FAIL beq_taken: got %b want 1", obsPcw[2]); end
        runInstr(4'h1, 2'b10, 6'b100000, 4'd0, 3, 4'd0, 1'b0);
        total++; if (obsPcw[2] !== 1'b0) begin bad++; $display("[TB] FAIL bne_not_taken: got %b want 0", obsPcw[2]); end
    endtask

    task automatic test_logic_flags();
        runInstr(4'hE, 2'b00, 6'b001001, 4'd1, 4, 4'b0011, 1'b0);
        #1;
        total++; if (Flags !== 4'b0011) begin bad++; $display("[TB] FAIL adds_flags: got %b want 0011", Flags); end
        runInstr(4'hE, 2'b00, 6'b111001, 4'd1, 4, 4'b1000, 1'b0);
        #1;
        total++; if (Flags !== 4'b1011) begin bad++; $display("[TB] FAIL orrs_keep_cv: got %b want 1011", Flags); end
        total++; if (obsAluc[2] !== 2'b11) begin bad++; $display("[TB] FAIL orrs_aluctl: got %b want 11", obsAluc[2]); end
        runInstr(4'hE, 2'b00, 6'b001000, 4'd15, 4, 4'b0000, 1'b0);
        total++; if ({obsPcw[3], obsRw[3]} !== 2'b11) begin
            bad++; $display("[TB] FAIL add_pc_jump: got %b want 11", {obsPcw[3], obsRw[3]});
        end
    endtask

    task automatic test_nop();
        runInstr(4'hE, 2'b11, 6'b000000, 4'd15, 2, 4'd0, 1'b0);
        total++; if ({obsState[0], obsState[1]} !== 8'h01) begin
            bad++; $display("[TB] FAIL nop_states: got %h want 01", {obsState[0], obsState[1]});
        end
        total++; if ({obsPcw[1], obsIrw[1], obsMw[1], obsRw[1]} !== 4'b0000) begin
            bad++; $display("[TB] FAIL nop_decode_en: got %b want 0000", {obsPcw[1], obsIrw[1], obsMw[1], obsRw[1]});
        end
        #1;
        total++; if (State !== 4'd0) begin bad++; $display("[TB] FAIL nop_return: got %0d want 0", State); end
    endtask

    task automatic test_async_reset();
        runInstr(4'hE, 2'b01, 6'b011000, 4'd4, 3, 4'd0, 1'b0);
        #1;
        total++; if ({State, MemWrite} !== 5'b01011) begin
            bad++; $display("[TB] FAIL memwr_before_rst: got %b want 01011", {State, MemWrite});
        end
        #1 rst = 1'b0;
        #1;
        total++; if ({State, MemWrite} !== 5'b00000) begin
            bad++; $display("[TB] FAIL async_rst: got %b want 00000", {State, MemWrite});
        end
        total++; if (Flags !== 4'd0) begin bad++; $display("[TB] FAIL async_rst_flags: got %b want 0000", Flags); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] mFlags, c, r;
        logic [1:0] o;
        logic [5:0] f;
        int n;
        bit pass, isDp, isLoad, isStore, isB, isCmp, eRw, eMw, ePcw;
        #1 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mFlags = 4'd0;
        for (int i = 0; i < 80; i++) begin
            c = 4'($urandom); o = 2'($urandom); f = 6'($urandom);
            r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            n = instrLen(o, f);
            pass    = condPass(c, mFlags);
            isDp    = (o == 2'b00);
            isLoad  = (o == 2'b01) && f[0];
            isStore = (o == 2'b01) && !f[0];
            isB     = (o == 2'b10);
            isCmp   = isDp && (f[4:1] == 4'b1010);
            runInstr(c, o, f, r, n, 4'd0, 1'b1);
            for (int k = 0; k < n; k++) begin
                eRw  = pass && ((isDp && k == 3 && !isCmp) || (isLoad && k == 4));
                eMw  = pass && isStore && k == 3;
                ePcw = (k == 0) || (pass && isB && k == 2) || (eRw && r == 4'd15);
                total++; if (obsState[k] !== phaseState(o, f, k)) begin
                    bad++; $display("[TB] FAIL rnd%0d_state[%0d]: got %0d want %0d", i, k, obsState[k], phaseState(o, f, k));
                end
                total++; if ({obsPcw[k], obsIrw[k], obsMw[k], obsRw[k]} !== {ePcw, k == 0, eMw, eRw}) begin
                    bad++; $display("[TB] FAIL rnd%0d_en[%0d]: got %b want %b (cond=%h op=%b funct=%b rd=%0d)", i, k,
                                    {obsPcw[k], obsIrw[k], obsMw[k], obsRw[k]}, {ePcw, k == 0, eMw, eRw}, c, o, f, r);
                end
            end
            if (isDp) begin
                total++; if (obsAluc[2] !== aluModel(f[4:1])) begin
                    bad++; $display("[TB] FAIL rnd%0d_aluctl: got %b want %b", i, obsAluc[2], aluModel(f[4:1]));
                end
                if (f[0] && pass) begin
                    mFlags[3:2] = aluIn[2][3:2];
                    if (f[4:1] != 4'b0000 && f[4:1] != 4'b1100)
                        mFlags[1:0] = aluIn[2][1:0];
                end
            end
            #1;
            total++; if (Flags !== mFlags) begin bad++; $display("[TB] FAIL rnd%0d_flags: got %b want %b", i, Flags, mFlags); end
        end
    endtask

    initial begin
        rst = 1'b0;
        Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_load();
        test_store_cond();
        test_cmp_branch();
        test_logic_flags();
        test_nop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
